// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample pacer.
package dac_pkg;

    // Playback state: wait for prefill, or replay at the paced rate.
    typedef enum logic {
        FILL = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Midscale code driven before the first sample reaches the DAC.
    localparam logic [15:0] IDLE_CODE_DEFAULT = 16'h8000;

    // FIFO depth in words for a given address width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Single-clock synchronous FIFO with registered read data and an
// occupancy counter; full/empty are derived from the counter so the
// pointers can wrap naturally.
module dac_sample_fifo
    import dac_pkg::*;
#(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       ADDR_W     = 10,
    parameter logic [DATA_W-1:0] RESET_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam int unsigned       DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign full  = (level == DEPTH_LVL);
    assign empty = (level == '0);

    // Sample storage; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port. rd_data holds
    // its value between reads, so it doubles as the DAC output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= RESET_WORD;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// Buffers bursty samples from the UDP splitter and replays them to the
// DAC at one sample every CLK_DIV clocks once PREFILL words are queued.
module dac_sample_pacer
    import dac_pkg::*;
#(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       CLK_DIV   = 4,
    parameter int unsigned       PREFILL   = 512,
    parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr_status,
    output logic [DATA_W-1:0] dac_out,
    output logic              dac_stb,
    output logic              playing,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PREFILL_LVL = (ADDR_W + 1)'(PREFILL);
    localparam logic [15:0]     TICK_AT     = 16'(CLK_DIV - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        full;
    logic        empty;
    logic        tick;
    logic        wr_en;
    logic        rd_en;
    logic        drop;
    logic        starve;

    // A write is judged against the level at the start of the cycle, so a
    // pop in the same cycle never frees room for it.
    assign tick   = (state == PLAY) && (cnt == TICK_AT);
    assign wr_en  = in_valid && !full;
    assign drop   = in_valid && full;
    assign rd_en  = tick && !empty;
    assign starve = tick && empty;

    dac_sample_fifo #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_WORD(IDLE_CODE)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(in_data),
        .rd_en  (rd_en),
        .rd_data(dac_out),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );

    // Playback FSM with pacing counter; dac_stb marks the cycle the popped
    // word lands on dac_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= '0;
            playing <= 1'b0;
            dac_stb <= 1'b0;
        end else begin
            dac_stb <= rd_en;
            case (state)
                FILL: begin
                    cnt <= '0;
                    if (fifo_level >= PREFILL_LVL) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        cnt <= '0;
                        if (empty) begin
                            state   <= FILL;
                            playing <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    cnt     <= '0;
                    playing <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
            if (starve) begin
                underflow <= 1'b1;
            end else if (clr_status) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
- Sits directly downstream of the UDP 32→16-bit splitter.
- Absorbs its bursty 16-bit sample stream (data_valid/dac_data) into a FIFO.
- Replays samples to the DAC at a fixed rate of one sample every CLK_DIV clocks.
- Playback starts only after a prefill threshold is reached; underflow and overflow are reported through sticky status flags.

Parameters:
- DATA_W, 16: sample width.
- ADDR_W, 10: FIFO address width; DEPTH = 2**ADDR_W.
- CLK_DIV, 4: clocks per output sample; legal range 2..65535.
- PREFILL, 512: FIFO level required to enter or re-enter playback; legal range 1..DEPTH.
- IDLE_CODE, 16'h8000: DAC code driven after reset, before the first sample (midscale).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe from the splitter (its data_valid).
- in_data  in  DATA_W  sample from the splitter (its dac_data).
- clr_status  in  1  one-cycle pulse; clears the sticky flags.
- dac_out  out  DATA_W  registered DAC code.
- dac_stb  out  1  one-cycle pulse, high when dac_out takes a new sample.
- playing  out  1  high while in PLAY state.
- fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- underflow  out  1  sticky: a pacing tick found the FIFO empty.

Behaviour:
- Reset values (sync, rst high at a clk edge):
  - dac_out=IDLE_CODE, dac_stb=0, playing=0, fifo_level=0, overflow=0, underflow=0.
  - FIFO pointers cleared; state=FILL; pacing counter=0.
  - Reset mid-operation discards all FIFO contents.
- Write side:
  - Sample is written iff in_valid=1 and fifo_level<DEPTH at the start of the cycle.
  - If in_valid=1 and fifo_level==DEPTH, the sample is dropped and overflow is set.
  - A read in the same cycle does not make room for that write.
  - Writes are accepted in every state.
- State machine, FILL:
  - playing=0; counter held at 0; dac_out holds its value.
  - Go to PLAY the cycle after fifo_level>=PREFILL is first seen.
- State machine, PLAY:
  - playing=1; counter counts 0..CLK_DIV-1 and wraps; tick when counter==CLK_DIV-1.
  - The first tick falls CLK_DIV cycles after entry.
  - Tick with FIFO non-empty: pop one word.
  - Tick with FIFO empty: no pop; underflow set; dac_out holds the last sample; next state FILL; counter reset.
- Read latency:
  - The popped word appears on dac_out exactly 1 cycle after the tick cycle (synchronous RAM read).
  - dac_stb=1 in that same cycle only.
  - dac_stb is never high on an underflow tick.
- Output order: samples leave in exact write order; no duplication; no skip except drops on overflow.
- fifo_level:
  - +1 on an accepted write; −1 on a pop.
  - Unchanged on a simultaneous accepted write and pop.
  - Registered, so it reflects operations of the previous cycle.
- Pointers: ADDR_W-bit with natural wrap-around; full/empty derived from the level counter.
- Sticky flags:
  - clr_status clears both flags.
  - If a new overflow or underflow event occurs in the same cycle as clr_status, the event wins and the flag stays 1.

Decomposition:
- Package dac_pkg:
  - state typedef (FILL, PLAY).
  - Default IDLE_CODE constant.
  - Function for DEPTH from ADDR_W.
- Sub-module dac_sample_fifo:
  - Single-clock synchronous FIFO: dual-port RAM, write/read pointers, level counter.
  - Provides wr_en/rd_en, registered rd_data, level, full, empty.
- The pacer holds the FSM, pacing counter, output register and sticky flags.

Test Plan (ADDR_W=4, PREFILL=4, CLK_DIV=4 unless stated):
- Reset then idle:
  - Write nothing for 50 cycles → dac_out=16'h8000, playing=0, dac_stb never 1.
- Prefill and playback:
  - Write 0x0001..0x0006 on consecutive cycles → playing rises the cycle after level first reads 4.
  - dac_stb pulses every 4 cycles carrying 0x0001..0x0006 in order.
- Underflow and refill:
  - After the 6 samples drain, the next tick → underflow=1, dac_out holds 0x0006, state FILL.
  - Write 4 more samples → playback resumes with those samples.
- Overflow:
  - Write 20 samples back-to-back with no playback started (PREFILL=16) → level saturates at 16; overflow=1.
  - Samples 17..20 are dropped; output later shows 1..16 only.
- Sticky clear race:
  - clr_status in the same cycle as a dropped write → overflow stays 1.
  - A later clr_status with no event → overflow=0.
- Reset mid-play:
  - Assert rst while playing with level=5 → next cycle level=0, dac_out=16'h8000, flags 0, state FILL.
